stream_demux_1to2: RTL and testbench
====================================

// Module: stream_demux_1to2
// PURPOSE
//   Packet-aware 1-to-2 stream demultiplexer: the distributing counterpart of mux_2to1.
//   Accepts one valid/ready input stream and steers each packet to output port 0 or 1.
//   Each output port has a one-entry registered stage.
//   Sits between a single producer and two consumers in combinational/stream datapath tests.
// PARAMETERS
//   DATA_W  8   payload width in bits
//   CNT_W   16  width of per-port packet counters (DEMUX_STATS_EN only)
// PORTS
//   clk         in   1       single clock, rising edge
//   rst_n       in   1       asynchronous active-low reset
//   in_valid    in   1       input beat valid
//   in_ready    out  1       input beat accepted when in_valid & in_ready
//   in_data     in   DATA_W  input payload
//   in_last     in   1       final beat of packet
//   in_sel      in   1       destination port; sampled on first beat of packet only
//   out0_valid  out  1       port 0 beat valid
//   out0_ready  in   1       port 0 consumer ready
//   out0_data   out  DATA_W  port 0 payload
//   out0_last   out  1       port 0 last flag
//   out1_valid  out  1       port 1 beat valid
//   out1_ready  in   1       port 1 consumer ready
//   out1_data   out  DATA_W  port 1 payload
//   out1_last   out  1       port 1 last flag
//   pkt_cnt0    out  CNT_W   packets delivered into port 0 (stats)
//   pkt_cnt1    out  CNT_W   packets delivered into port 1 (stats)
// BEHAVIOUR
//   - Reset (async assert, sync-safe deassert): FSM=IDLE, route_q=0, all outN_valid/data/last=0, counters=0.
//   - FSM IDLE: target=in_sel. Accepted beat with in_last=0 -> PKT, route_q<=in_sel.
//     Accepted beat with in_last=1 (single-beat packet) -> stay IDLE.
//   - FSM PKT: target=route_q; in_sel ignored (X tolerated). Accepted beat with in_last=1 -> IDLE.
//   - Per-port stage N can load when !outN_valid | outN_ready (drain and reload in the same cycle).
//   - in_ready = loadable(target). It depends combinationally on in_sel/route_q and outN_ready.
//     It does not depend on in_valid.
//   - Accepted beat appears on target port next cycle (latency 1). Full rate: 1 beat/cycle per stream.
//   - outN_data/outN_last held stable while outN_valid & !outN_ready; outN_valid never drops without a handshake.
//   - Non-target port is untouched by input traffic. Both ports may drain in the same cycle.
//   - A stalled port blocks only the input while it is the target. Nothing can bypass in the input order.
//   - No beat is duplicated, dropped or reordered. Beats of one packet all go to one port.
//   - Reset mid-packet: pending beats discarded, FSM returns to IDLE, next beat is treated as first beat.
// CONFIGURATION
//   DEMUX_STATS_EN defined:
//     - pkt_cntN increments by 1 on each accepted in_last beat routed to port N; wraps 2^CNT_W-1 -> 0.
//   DEMUX_STATS_EN undefined:
//     - Counter logic is not built; pkt_cnt0/pkt_cnt1 are tied to 0.
//     - Port list is unchanged.
// TESTING
//   1. Reset with rst_n=0 for 3 cycles
//      -> all outN_valid=0, outN_data=0; in_ready=1 with both outN_ready=1.
//   2. Single-beat packets, both outN_ready=1: sel=0 data=0xA5, then sel=1 data=0x3C, back-to-back
//      -> out0 gets 0xA5 at cycle+1, out1 gets 0x3C at cycle+2; in_ready stays 1.
//   3. 4-beat packet 0x10..0x13, sel=1 on beat 0, sel toggled on beats 1-3
//      -> all four beats on out1 in order, last=1 only on 0x13; out0_valid stays 0.
//   4. out0_ready=0 with 0x55 held in port 0; send sel=0 beat 0x66
//      -> in_ready=0 and out0_data holds 0x55.
//      Raise out0_ready -> 0x55 then 0x66 delivered; a sel=1 beat while port 0 stalls passes to out1.
//   5. Assert rst_n=0 after beat 2 of a 4-beat sel=1 packet
//      -> outputs clear; next first beat with sel=0 routes to out0.
//   6. With DEMUX_STATS_EN, CNT_W=2: send 5 packets to port 0 -> pkt_cnt0=1 (wrap), pkt_cnt1=0.
//      Without DEMUX_STATS_EN -> both counters read 0.

Source files
------------

// File: rtl/stream_demux_1to2.sv
// Packet-aware 1-to-2 valid/ready demux with one registered stage per port.
// Define DEMUX_STATS_EN to build the per-port delivered-packet counters.
module stream_demux_1to2 #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  input  logic              in_sel,
  output logic              out0_valid,
  input  logic              out0_ready,
  output logic [DATA_W-1:0] out0_data,
  output logic              out0_last,
  output logic              out1_valid,
  input  logic              out1_ready,
  output logic [DATA_W-1:0] out1_data,
  output logic              out1_last,
  output logic [CNT_W-1:0]  pkt_cnt0,
  output logic [CNT_W-1:0]  pkt_cnt1
);

  typedef enum logic {
    IDLE = 1'b0,
    PKT  = 1'b1
  } state_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              last;
  } beat_t;

  state_t state_q;
  logic   route_q;
  logic   target;
  logic   ld0;
  logic   ld1;
  logic   acc;
  logic   acc0;
  logic   acc1;
  beat_t  beat;
  beat_t  p0_q;
  beat_t  p1_q;

  // in_sel only matters on the first beat of a packet
  assign target   = (state_q == PKT) ? route_q : in_sel;
  assign ld0      = !out0_valid | out0_ready;
  assign ld1      = !out1_valid | out1_ready;
  assign in_ready = target ? ld1 : ld0;
  assign acc      = in_valid & in_ready;
  assign acc0     = acc & !target;
  assign acc1     = acc & target;
  assign beat     = '{data: in_data, last: in_last};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      route_q <= 1'b0;
    end else if (acc) begin
      unique case (state_q)
        IDLE: begin
          if (!in_last) begin
            state_q <= PKT;
            route_q <= in_sel;
          end
        end
        PKT: begin
          if (in_last) state_q <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out0_valid <= 1'b0;
      p0_q       <= '0;
    end else if (ld0) begin
      out0_valid <= acc0;
      if (acc0) p0_q <= beat;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out1_valid <= 1'b0;
      p1_q       <= '0;
    end else if (ld1) begin
      out1_valid <= acc1;
      if (acc1) p1_q <= beat;
    end
  end

  assign out0_data = p0_q.data;
  assign out0_last = p0_q.last;
  assign out1_data = p1_q.data;
  assign out1_last = p1_q.last;

`ifdef DEMUX_STATS_EN
  logic [CNT_W-1:0] cnt0_q;
  logic [CNT_W-1:0] cnt1_q;

  // counts wrap naturally at 2^CNT_W
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      if (acc0 && in_last) cnt0_q <= cnt0_q + 1'b1;
      if (acc1 && in_last) cnt1_q <= cnt1_q + 1'b1;
    end
  end

  assign pkt_cnt0 = cnt0_q;
  assign pkt_cnt1 = cnt1_q;
`else
  assign pkt_cnt0 = '0;
  assign pkt_cnt1 = '0;
`endif

endmodule

// File: tb/tb_stream_demux_1to2.sv
// Directed table-driven bench for stream_demux_1to2.
// Counter expectations follow DEMUX_STATS_EN.
module tb_stream_demux_1to2;

  localparam int DW = 8;
  localparam int CW = 2;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          in_last;
  logic          in_sel;
  logic          out0_valid;
  logic          out0_ready;
  logic [DW-1:0] out0_data;
  logic          out0_last;
  logic          out1_valid;
  logic          out1_ready;
  logic [DW-1:0] out1_data;
  logic          out1_last;
  logic [CW-1:0] pkt_cnt0;
  logic [CW-1:0] pkt_cnt1;

  int checks;
  int errors;

  stream_demux_1to2 #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_last    (in_last),
    .in_sel     (in_sel),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out0_data  (out0_data),
    .out0_last  (out0_last),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .out1_data  (out1_data),
    .out1_last  (out1_last),
    .pkt_cnt0   (pkt_cnt0),
    .pkt_cnt1   (pkt_cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic          valid;
    logic          sel;
    logic [DW-1:0] data;
    logic          last;
    logic          r0;
    logic          r1;
    logic          rdy;
    logic          o0v;
    logic [DW-1:0] o0d;
    logic          o0l;
    logic          o1v;
    logic [DW-1:0] o1d;
    logic          o1l;
  } vec_t;

  vec_t vt[12];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic s, input logic [DW-1:0] d,
                       input logic l);
    in_valid = v;
    in_sel   = s;
    in_data  = d;
    in_last  = l;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input int i);
    vec_t v;
    v = vt[i];
    drive(v.valid, v.sel, v.data, v.last);
    out0_ready = v.r0;
    out1_ready = v.r1;
    #1;
    chk($sformatf("v%0d in_ready", i), 32'(in_ready), 32'(v.rdy));
    step();
    chk($sformatf("v%0d out0_valid", i), 32'(out0_valid), 32'(v.o0v));
    chk($sformatf("v%0d out0_data", i), 32'(out0_data), 32'(v.o0d));
    chk($sformatf("v%0d out0_last", i), 32'(out0_last), 32'(v.o0l));
    chk($sformatf("v%0d out1_valid", i), 32'(out1_valid), 32'(v.o1v));
    chk($sformatf("v%0d out1_data", i), 32'(out1_data), 32'(v.o1d));
    chk($sformatf("v%0d out1_last", i), 32'(out1_last), 32'(v.o1l));
  endtask

  initial begin
    logic [CW-1:0] exp_c0;
    checks = 0;
    errors = 0;

    //  vld sel data  lst r0 r1 | rdy o0v o0d  o0l o1v o1d  o1l
    vt[0]  = '{1, 0, 8'hA5, 1, 1, 1, 1, 1, 8'hA5, 1, 0, 8'h00, 0};
    vt[1]  = '{1, 1, 8'h3C, 1, 1, 1, 1, 0, 8'hA5, 1, 1, 8'h3C, 1};
    vt[2]  = '{1, 1, 8'h10, 0, 1, 1, 1, 0, 8'hA5, 1, 1, 8'h10, 0};
    vt[3]  = '{1, 0, 8'h11, 0, 1, 1, 1, 0, 8'hA5, 1, 1, 8'h11, 0};
    vt[4]  = '{1, 1, 8'h12, 0, 1, 1, 1, 0, 8'hA5, 1, 1, 8'h12, 0};
    vt[5]  = '{1, 0, 8'h13, 1, 1, 1, 1, 0, 8'hA5, 1, 1, 8'h13, 1};
    vt[6]  = '{0, 0, 8'h00, 0, 1, 1, 1, 0, 8'hA5, 1, 0, 8'h13, 1};
    vt[7]  = '{1, 0, 8'h55, 1, 1, 1, 1, 1, 8'h55, 1, 0, 8'h13, 1};
    vt[8]  = '{1, 0, 8'h66, 1, 0, 1, 0, 1, 8'h55, 1, 0, 8'h13, 1};
    vt[9]  = '{1, 1, 8'h77, 1, 0, 1, 1, 1, 8'h55, 1, 1, 8'h77, 1};
    vt[10] = '{1, 0, 8'h66, 1, 1, 1, 1, 1, 8'h66, 1, 0, 8'h77, 1};
    vt[11] = '{0, 0, 8'h00, 0, 1, 1, 1, 0, 8'h66, 1, 0, 8'h77, 1};

    rst_n = 1'b0;
    drive(0, 0, '0, 0);
    out0_ready = 1'b1;
    out1_ready = 1'b1;
    repeat (3) step();
    chk("rst out0_valid", 32'(out0_valid), 0);
    chk("rst out0_data", 32'(out0_data), 0);
    chk("rst out1_valid", 32'(out1_valid), 0);
    chk("rst out1_data", 32'(out1_data), 0);
    chk("rst in_ready", 32'(in_ready), 1);
    chk("rst pkt_cnt0", 32'(pkt_cnt0), 0);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 12; i++) run_vec(i);

    // reset in the middle of a sel=1 packet
    drive(1, 1, 8'h20, 0);
    step();
    drive(1, 0, 8'h21, 0);
    step();
    chk("mid out1_data", 32'(out1_data), 32'h21);
    drive(0, 0, '0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid rst out1_valid", 32'(out1_valid), 0);
    chk("mid rst out1_data", 32'(out1_data), 0);
    step();
    rst_n = 1'b1;
    drive(1, 0, 8'h30, 0);
    step();
    chk("post rst out0_valid", 32'(out0_valid), 1);
    chk("post rst out0_data", 32'(out0_data), 32'h30);
    chk("post rst out1_valid", 32'(out1_valid), 0);
    drive(1, 1, 8'h31, 1);
    step();
    chk("post rst tail out0", 32'(out0_data), 32'h31);
    chk("post rst tail last", 32'(out0_last), 1);

    // counters: five single-beat packets to port 0 after a clean reset
    drive(0, 0, '0, 0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    for (int k = 0; k < 5; k++) begin
      drive(1, 0, 8'(8'h40 + k), 1);
      step();
    end
    drive(0, 0, '0, 0);
    step();
`ifdef DEMUX_STATS_EN
    exp_c0 = 2'd1;
`else
    exp_c0 = 2'd0;
`endif
    chk("pkt_cnt0", 32'(pkt_cnt0), 32'(exp_c0));
    chk("pkt_cnt1", 32'(pkt_cnt1), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
